// File: rtl/ghash_r_table_builder.sv
// ghash_r_table_builder: builds the GHASH reduction lookup table into a
// register array and serves registered reads from it once the table is valid.
// Entry i is the XOR of the reduction constant 8'hE1, aligned above NB_WIN
// zero bits and shifted right by b, over every set bit b of i.
// Optional feature: define GHASH_R_TABLE_BUILDER_RD1_EN to add a second,
// independent read port (i_rd1_valid, i_rd1_index, o_rd1_data, o_rd1_valid).
module ghash_r_table_builder #(
    parameter int unsigned NB_BYTE  = 8,
    parameter int unsigned NB_WIN   = 8,
    parameter int unsigned NB_LANES = 1
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic                        i_rd_valid,
    input  logic [NB_WIN-1:0]           i_rd_index,
    output logic [NB_WIN+NB_BYTE-1:0]   o_rd_data,
    output logic                        o_rd_valid,
`ifdef GHASH_R_TABLE_BUILDER_RD1_EN
    input  logic                        i_rd1_valid,
    input  logic [NB_WIN-1:0]           i_rd1_index,
    output logic [NB_WIN+NB_BYTE-1:0]   o_rd1_data,
    output logic                        o_rd1_valid,
`endif
    output logic                        o_busy,
    output logic                        o_ready,
    output logic                        o_done
);

    localparam int unsigned NB_ENTRY = NB_WIN + NB_BYTE;
    localparam int unsigned DEPTH    = 1 << NB_WIN;
    // One extra bit so the increment after the last lane group reaches DEPTH
    // instead of wrapping back onto index 0.
    localparam int unsigned NB_CNT   = NB_WIN + 1;

    localparam logic [NB_BYTE-1:0]  RED_CONST = NB_BYTE'(8'hE1);
    localparam logic [NB_ENTRY-1:0] MOD0      = {RED_CONST, {NB_WIN{1'b0}}};
    localparam logic [NB_CNT-1:0]   LANE_STEP = NB_CNT'(NB_LANES);
    localparam logic [NB_CNT-1:0]   LAST_CNT  = NB_CNT'(DEPTH - NB_LANES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [NB_CNT-1:0]   cnt_q, cnt_d;
    logic                busy_q, ready_q, done_q;
    logic                fill_last;
    logic [NB_WIN-1:0]   wr_base;
    logic [NB_ENTRY-1:0] tbl_q [DEPTH];

    logic                rd0_acc;
    logic                rd0_valid_q;
    logic [NB_ENTRY-1:0] rd0_data_q;

    // Table entry for a given index: XOR of shifted reduction constants.
    function automatic logic [NB_ENTRY-1:0] entry_of(input logic [NB_WIN-1:0] idx);
        logic [NB_ENTRY-1:0] acc;
        acc = '0;
        for (int b = 0; b < int'(NB_WIN); b++) begin
            if (idx[b]) begin
                acc = acc ^ (MOD0 >> b);
            end
        end
        return acc;
    endfunction

    assign wr_base   = cnt_q[NB_WIN-1:0];
    assign fill_last = (state_q == ST_FILL) && (cnt_q == LAST_CNT);
    assign rd0_acc   = i_rd_valid && ready_q;

    // Next-state and fill-counter logic; i_start is only honoured outside FILL.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                end
            end
            ST_FILL: begin
                cnt_d = cnt_q + LANE_STEP;
                if (fill_last) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (i_start) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered status flags.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == ST_FILL);
            ready_q <= (state_d == ST_READY);
            done_q  <= fill_last;
        end
    end

    // Table storage: NB_LANES consecutive entries per FILL cycle, never cleared.
    always_ff @(posedge i_clock) begin
        if (!i_reset && (state_q == ST_FILL)) begin
            for (int l = 0; l < int'(NB_LANES); l++) begin
                tbl_q[wr_base + NB_WIN'(l)] <= entry_of(wr_base + NB_WIN'(l));
            end
        end
    end

    // Read port 0: one-cycle registered read, zero data when not accepted.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rd0_valid_q <= 1'b0;
            rd0_data_q  <= '0;
        end else begin
            rd0_valid_q <= rd0_acc;
            rd0_data_q  <= rd0_acc ? tbl_q[i_rd_index] : '0;
        end
    end

    assign o_rd_valid = rd0_valid_q;
    assign o_rd_data  = rd0_data_q;
    assign o_busy     = busy_q;
    assign o_ready    = ready_q;
    assign o_done     = done_q;

`ifdef GHASH_R_TABLE_BUILDER_RD1_EN
    logic                rd1_acc;
    logic                rd1_valid_q;
    logic [NB_ENTRY-1:0] rd1_data_q;

    assign rd1_acc = i_rd1_valid && ready_q;

    // Read port 1: identical behaviour to port 0, fully independent.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rd1_valid_q <= 1'b0;
            rd1_data_q  <= '0;
        end else begin
            rd1_valid_q <= rd1_acc;
            rd1_data_q  <= rd1_acc ? tbl_q[i_rd1_index] : '0;
        end
    end

    assign o_rd1_valid = rd1_valid_q;
    assign o_rd1_data  = rd1_data_q;
`endif

endmodule

// File: tb/tb_ghash_r_table_builder.sv
// Scoreboard bench for ghash_r_table_builder: a wide single-lane instance
// (NB_WIN=8, NB_LANES=1) and a narrow multi-lane one (NB_WIN=4, NB_LANES=4).
module tb_ghash_r_table_builder;

    typedef struct {
        int unsigned data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;

    exp_t q8[$];
    exp_t q4[$];
    exp_t e8, e4;

    // wide instance signals
    logic        s8 = 1'b0, rv8 = 1'b0;
    logic [7:0]  ri8 = '0;
    logic [15:0] rd8;
    logic        ov8, busy8, ready8, done8;
    // narrow instance signals
    logic        s4 = 1'b0, rv4 = 1'b0;
    logic [3:0]  ri4 = '0;
    logic [11:0] rd4;
    logic        ov4, busy4, ready4, done4;

`ifdef GHASH_R_TABLE_BUILDER_RD1_EN
    exp_t q8b[$];
    exp_t e8b;
    logic        rv1_8 = 1'b0;
    logic [7:0]  ri1_8 = '0;
    logic [15:0] rd1_8;
    logic        ov1_8;
    logic [11:0] rd1_4;
    logic        ov1_4;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ghash_r_table_builder #(.NB_BYTE(8), .NB_WIN(8), .NB_LANES(1)) dut8 (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_start    (s8),
        .i_rd_valid (rv8),
        .i_rd_index (ri8),
        .o_rd_data  (rd8),
        .o_rd_valid (ov8),
`ifdef GHASH_R_TABLE_BUILDER_RD1_EN
        .i_rd1_valid(rv1_8),
        .i_rd1_index(ri1_8),
        .o_rd1_data (rd1_8),
        .o_rd1_valid(ov1_8),
`endif
        .o_busy     (busy8),
        .o_ready    (ready8),
        .o_done     (done8)
    );

    ghash_r_table_builder #(.NB_BYTE(8), .NB_WIN(4), .NB_LANES(4)) dut4 (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_start    (s4),
        .i_rd_valid (rv4),
        .i_rd_index (ri4),
        .o_rd_data  (rd4),
        .o_rd_valid (ov4),
`ifdef GHASH_R_TABLE_BUILDER_RD1_EN
        .i_rd1_valid(1'b0),
        .i_rd1_index(4'h0),
        .o_rd1_data (rd1_4),
        .o_rd1_valid(ov1_4),
`endif
        .o_busy     (busy4),
        .o_ready    (ready4),
        .o_done     (done4)
    );

    // Reference table: XOR over set index bits of (0xE1 << nbwin) >> bit.
    function automatic int unsigned ref_entry(input int nbwin, input int idx);
        int unsigned top, acc;
        top = 32'hE1 << nbwin;
        acc = 0;
        for (int b = 0; b < nbwin; b++) begin
            if (((idx >> b) & 1) == 1) acc = acc ^ (top >> b);
        end
        return acc;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: pop one expectation per valid read response, else require zero data.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ov8 === 1'b1) begin
                if (q8.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd8_unexpected: got valid data %0h expected no response", rd8);
                end else begin
                    e8 = q8.pop_front();
                    chk("rd8_data", longint'(rd8), longint'(e8.data));
                    chk("rd8_cycle", longint'(cyc), longint'(e8.cyc));
                end
            end else begin
                chk("rd8_valid_low", longint'(ov8), 0);
                chk("rd8_idle_zero", longint'(rd8), 0);
            end
            if (ov4 === 1'b1) begin
                if (q4.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd4_unexpected: got valid data %0h expected no response", rd4);
                end else begin
                    e4 = q4.pop_front();
                    chk("rd4_data", longint'(rd4), longint'(e4.data));
                    chk("rd4_cycle", longint'(cyc), longint'(e4.cyc));
                end
            end else begin
                chk("rd4_idle_zero", longint'(rd4), 0);
            end
`ifdef GHASH_R_TABLE_BUILDER_RD1_EN
            if (ov1_8 === 1'b1) begin
                if (q8b.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd1_unexpected: got valid data %0h expected no response", rd1_8);
                end else begin
                    e8b = q8b.pop_front();
                    chk("rd1_data", longint'(rd1_8), longint'(e8b.data));
                    chk("rd1_cycle", longint'(cyc), longint'(e8b.cyc));
                end
            end else begin
                chk("rd1_idle_zero", longint'(rd1_8), 0);
            end
`endif
        end
    end

    // Start a fill on the wide instance and observe it; optional mid-fill
    // start, mid-fill reset, and a read issued alongside the start.
    task automatic fill8(input int inj_at, input int rst_at, input int rd_idx,
                         output int nbusy, output int ndone, output bit ok);
        nbusy = 0; ndone = 0; ok = 1'b0;
        @(posedge clk); #1;
        s8 = 1'b1;
        if (rd_idx >= 0) begin
            rv8 = 1'b1;
            ri8 = 8'(rd_idx);
            q8.push_back('{data: ref_entry(8, rd_idx), cyc: cyc + 1});
        end
        for (int i = 1; i <= 600; i++) begin
            @(posedge clk); #1;
            s8  = (i == inj_at);
            rst = (i == rst_at);
            rv8 = 1'b0;
            @(negedge clk);
            if (busy8) nbusy++;
            if (done8) ndone++;
            if (rst_at > 0 && i == rst_at + 1) begin ok = 1'b1; break; end
            if (ready8) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        s8 = 1'b0; rst = 1'b0;
    endtask

    task automatic read_not_ready8(input int idx);
        @(posedge clk); #1;
        rv8 = 1'b1; ri8 = 8'(idx);
        @(posedge clk); #1;
        rv8 = 1'b0;
        @(negedge clk);
        chk("nr_rd_valid", longint'(ov8), 0);
        chk("nr_rd_data", longint'(rd8), 0);
    endtask

    int nbusy, ndone, idx;
    bit ok;
    int unsigned spec_idx[5]  = '{32'h00, 32'h01, 32'h03, 32'h80, 32'hFF};
    int unsigned spec_data[5] = '{32'h0000, 32'hE100, 32'h9180, 32'h01C2, 32'hBEBE};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", longint'(busy8), 0);
        chk("rst_ready", longint'(ready8), 0);
        chk("rst_done", longint'(done8), 0);
        chk("rst_rd_valid", longint'(ov8), 0);
        chk("rst_rd_data", longint'(rd8), 0);
        chk("rst_busy4", longint'(busy4), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // reads before any fill are refused
        read_not_ready8(8'h05);

        // plain fill from IDLE
        fill8(-1, -1, -1, nbusy, ndone, ok);
        chk("fill_finished", longint'(ok), 1);
        chk("fill_busy_cycles", longint'(nbusy), 256);
        chk("fill_done_pulses", longint'(ndone), 1);
        @(negedge clk);
        chk("done_single_pulse", longint'(done8), 0);
        chk("ready_held", longint'(ready8), 1);

        // back-to-back reads with known values
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            rv8 = 1'b1; ri8 = 8'(spec_idx[k]);
            q8.push_back('{data: spec_data[k], cyc: cyc + 1});
        end
        @(posedge clk); #1; rv8 = 1'b0;

        // randomized reads with random gaps
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            ri8 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                rv8 = 1'b1;
                q8.push_back('{data: ref_entry(8, int'(ri8)), cyc: cyc + 1});
            end else begin
                rv8 = 1'b0;
            end
        end
        @(posedge clk); #1; rv8 = 1'b0;

        // start while filling is ignored
        fill8(50, -1, -1, nbusy, ndone, ok);
        chk("inj_finished", longint'(ok), 1);
        chk("inj_busy_cycles", longint'(nbusy), 256);
        chk("inj_done_pulses", longint'(ndone), 1);

        // read and rebuild in the same READY cycle
        idx = int'($urandom_range(0, 255));
        fill8(-1, -1, idx, nbusy, ndone, ok);
        chk("rdstart_finished", longint'(ok), 1);
        chk("rdstart_busy_cycles", longint'(nbusy), 256);
        chk("rdstart_done_pulses", longint'(ndone), 1);

        // reset at fill cycle 100 aborts, then a full rebuild
        fill8(-1, 100, -1, nbusy, ndone, ok);
        chk("abort_busy_cycles", longint'(nbusy), 100);
        chk("abort_no_done", longint'(ndone), 0);
        chk("abort_busy_low", longint'(busy8), 0);
        chk("abort_ready_low", longint'(ready8), 0);
        read_not_ready8(8'hFF);
        fill8(-1, -1, -1, nbusy, ndone, ok);
        chk("refill_finished", longint'(ok), 1);
        chk("refill_busy_cycles", longint'(nbusy), 256);
        chk("refill_done_pulses", longint'(ndone), 1);
        @(posedge clk); #1;
        rv8 = 1'b1; ri8 = 8'hFF;
        q8.push_back('{data: 32'hBEBE, cyc: cyc + 1});
        @(posedge clk); #1; rv8 = 1'b0;

`ifdef GHASH_R_TABLE_BUILDER_RD1_EN
        // both ports in the same cycle
        @(posedge clk); #1;
        rv8 = 1'b1; ri8 = 8'h80;
        rv1_8 = 1'b1; ri1_8 = 8'hFF;
        q8.push_back('{data: 32'h01C2, cyc: cyc + 1});
        q8b.push_back('{data: 32'hBEBE, cyc: cyc + 1});
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            rv8 = 1'b0;
            rv1_8 = ($urandom_range(0, 1) == 1);
            ri1_8 = 8'($urandom_range(0, 255));
            if (rv1_8) q8b.push_back('{data: ref_entry(8, int'(ri1_8)), cyc: cyc + 1});
        end
        @(posedge clk); #1; rv1_8 = 1'b0;
`endif

        // narrow multi-lane instance
        @(posedge clk); #1; s4 = 1'b1;
        nbusy = 0; ndone = 0; ok = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1; s4 = 1'b0;
            @(negedge clk);
            if (busy4) nbusy++;
            if (done4) ndone++;
            if (ready4) begin ok = 1'b1; break; end
        end
        chk("f4_finished", longint'(ok), 1);
        chk("f4_busy_cycles", longint'(nbusy), 4);
        chk("f4_done_pulses", longint'(ndone), 1);
        @(posedge clk); #1;
        rv4 = 1'b1; ri4 = 4'h1;
        q4.push_back('{data: 32'hE10, cyc: cyc + 1});
        @(posedge clk); #1;
        ri4 = 4'hF;
        q4.push_back('{data: ref_entry(4, 15), cyc: cyc + 1});
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            ri4 = 4'(15 - k);
            q4.push_back('{data: ref_entry(4, 15 - k), cyc: cyc + 1});
        end
        @(posedge clk); #1; rv4 = 1'b0;

        // drain and confirm every expected response arrived
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("q8_drained", longint'(q8.size()), 0);
        chk("q4_drained", longint'(q4.size()), 0);
`ifdef GHASH_R_TABLE_BUILDER_RD1_EN
        chk("q8b_drained", longint'(q8b.size()), 0);
`endif
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ghash_r_table_builder.md
GHASH_R_TABLE_BUILDER -- requirements
Module: ghash_r_table_builder

Interface
REQ-001 SHALL have parameter NB_BYTE, default 8: byte width and width of the reduction constant 8'hE1.
REQ-002 SHALL have parameter NB_WIN, default 8: table index width in bits, legal values 1..8; the table depth is 2^NB_WIN.
REQ-003 SHALL have parameter NB_LANES, default 1: entries written per fill cycle; must be a power of two no larger than 2^NB_WIN.
REQ-004 SHALL define derived width NB_ENTRY = NB_WIN+NB_BYTE.
REQ-005 i_clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_start  input  1  request a table (re)build.
REQ-008 i_rd_valid  input  1  read request, port 0.
REQ-009 i_rd_index  input  NB_WIN  read address, port 0.
REQ-010 o_rd_data  output  NB_ENTRY  read data, port 0.
REQ-011 o_rd_valid  output  1  o_rd_data qualifier, port 0.
REQ-012 o_busy  output  1  high while in FILL.
REQ-013 o_ready  output  1  high while in READY (table valid).
REQ-014 o_done  output  1  one-cycle pulse on completion of a fill.

Function
REQ-015 Entry i SHALL equal the XOR over all bits b (0..NB_WIN-1) with i[b]=1 of MOD[b], where MOD[0] = 8'hE1 followed by NB_WIN zero bits and MOD[b] = MOD[b-1] >> 1.
REQ-016 The FSM SHALL have exactly three states, IDLE, FILL and READY, and leave reset in IDLE.
REQ-017 i_start in IDLE or READY SHALL enter FILL on the next cycle with the fill counter at 0; o_ready SHALL drop in that same cycle.
REQ-018 i_start while in FILL SHALL be ignored; the fill in progress is not restarted.
REQ-019 Each FILL cycle SHALL write entries counter..counter+NB_LANES-1 into the register array and then advance the counter by NB_LANES.
REQ-020 A fill SHALL take exactly 2^NB_WIN/NB_LANES cycles; after the last write the FSM SHALL enter READY and assert o_done for that one cycle.
REQ-021 The counter SHALL be one bit wider than NB_WIN so that the final increment cannot wrap and alias index 0.
REQ-022 Read behaviour on port 0:
- A read is accepted only when i_rd_valid=1 and o_ready=1.
- One cycle after acceptance, o_rd_valid=1 and o_rd_data = entry[i_rd_index].
- Otherwise o_rd_valid=0 and o_rd_data=0.
REQ-023 If i_start and i_rd_valid are asserted in the same READY cycle, the read SHALL be accepted with the old table contents and the rebuild SHALL start in the same cycle.
REQ-024 Back-to-back reads SHALL be supported, one read per cycle with no bubbles.

Reset
REQ-025 While i_reset=1, the block SHALL force:
- state to IDLE and the counter to 0;
- o_rd_data=0 and o_rd_valid=0;
- o_busy=0, o_ready=0 and o_done=0.
REQ-026 The table array SHALL NOT be cleared on reset; it is unreadable until the next fill completes.
REQ-027 i_reset asserted mid-FILL SHALL abort the fill; a later i_start SHALL rebuild from index 0.
REQ-028 i_reset SHALL take priority over i_start.

Configuration
REQ-029 Macro GHASH_R_TABLE_BUILDER_RD1_EN defined: the block SHALL add a second, independent read port (i_rd1_valid, i_rd1_index, o_rd1_data, o_rd1_valid) with behaviour identical to REQ-022 to REQ-024.
REQ-030 Macro GHASH_R_TABLE_BUILDER_RD1_EN undefined: those four ports and their logic SHALL NOT exist.

Verification
REQ-031 NB_WIN=8, NB_LANES=1: reset, then pulse i_start -> o_busy high for 256 cycles, o_done pulses once, then o_ready=1.
REQ-032 NB_WIN=8, after fill, read indices 0x00, 0x01, 0x03, 0x80, 0xFF back to back -> 0x0000, 0xE100, 0x9180, 0x01C2, 0xBEBE on consecutive cycles.
REQ-033 NB_WIN=4, NB_LANES=4: fill -> 4 busy cycles; reading index 0x1 returns 0xE10 and index 0xF returns 0xD5E (12-bit entries).
REQ-034 Assert i_reset at fill cycle 100, then i_start -> full 256-cycle fill with no early o_done, and index 0xFF reads 0xBEBE.
REQ-035 Read with o_ready=0 -> o_rd_valid stays 0 and o_rd_data stays 0.
REQ-036 i_start during FILL -> fill length unchanged.
REQ-037 With GHASH_R_TABLE_BUILDER_RD1_EN defined, read port 0 at 0x80 and port 1 at 0xFF in the same cycle -> 0x01C2 and 0xBEBE one cycle later.
